// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative radix-2 multiply/divide unit in the EX stage. Multiply is
//   shift-add and divide is restoring. Each takes one operand bit per cycle.
//   Signed operations work on magnitudes and apply a sign fix-up at the end.
//   While an operation is in flight, md_busy stalls the pipeline. The final
//   64-bit {hi,lo} result is kept on md_hi/md_lo for the HI/LO write path.
//
// Ports
//   clk        in  1      rising-edge clock
//   reset      in  1      asynchronous active-high reset
//   refresh    in  1      synchronous flush; aborts any operation
//   ex_stall   in  1      EX held by another source
//   ex_mult    in  1      EX instruction is MULT/MULTU (wins over ex_div)
//   ex_div     in  1      EX instruction is DIV/DIVU
//   ex_mdsign  in  1      signed operation
//   ex_A       in  WIDTH  multiplicand / dividend
//   ex_B       in  WIDTH  multiplier / divisor
//   md_busy    out 1      stall request (issue cycle, RUN and FIX)
//   md_valid   out 1      result valid (DONE state)
//   md_hi      out WIDTH  product high half / remainder
//   md_lo      out WIDTH  product low half / quotient
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refresh,
  input  logic             ex_stall,
  input  logic             ex_mult,
  input  logic             ex_div,
  input  logic             ex_mdsign,
  input  logic [WIDTH-1:0] ex_A,
  input  logic [WIDTH-1:0] ex_B,
  output logic             md_busy,
  output logic             md_valid,
  output logic [WIDTH-1:0] md_hi,
  output logic [WIDTH-1:0] md_lo
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
    return (~v) + W2'(1);
  endfunction

  // Magnitude of an operand; only signed operations with a negative value flip.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  state_t            state_r, next_state_s;
  logic              start_s;
  logic              op_mult_r, sa_r, sb_r;
  logic [CW-1:0]     cnt_r;
  logic [W2-1:0]     acc_r, mcand_r, acc_next_s;
  // opa_r: multiplier (shifted right) for mult, dividend/quotient (shifted left) for div
  logic [WIDTH-1:0]  opa_r, opb_r, rem_r;
  logic [WIDTH:0]    rem_shift_s;
  logic [WIDTH-1:0]  rem_next_s;
  logic              quo_bit_s;

  assign start_s  = (ex_mult | ex_div) & ~refresh;
  assign md_valid = (state_r == DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; refresh overrides every transition.
  always_comb begin
    next_state_s = state_r;
    if (refresh) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    next_state_s = start_s ? RUN : IDLE;
        RUN:     next_state_s = (cnt_r == LAST_CNT) ? FIX : RUN;
        FIX:     next_state_s = DONE;
        // A held EX instruction must not restart the operation it issued.
        DONE:    next_state_s = ex_stall ? DONE : IDLE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Stall request: asserted in the issue cycle so the pipeline holds at once.
  always_comb begin
    md_busy = 1'b0;
    case (state_r)
      IDLE:    md_busy = start_s;
      RUN:     md_busy = 1'b1;
      FIX:     md_busy = 1'b1;
      default: md_busy = 1'b0;
    endcase
  end

  // One iteration of each algorithm, evaluated from the current registers.
  always_comb begin
    rem_shift_s = {rem_r, opa_r[WIDTH-1]};
    // The remainder stays below the divisor, so a WIDTH-bit difference is exact.
    if (rem_shift_s >= {1'b0, opb_r}) begin
      rem_next_s = rem_shift_s[WIDTH-1:0] - opb_r;
      quo_bit_s  = 1'b1;
    end else begin
      rem_next_s = rem_shift_s[WIDTH-1:0];
      quo_bit_s  = 1'b0;
    end
    if (opa_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Datapath: operand latch, iteration, sign fix-up and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_mult_r <= 1'b0;
      sa_r      <= 1'b0;
      sb_r      <= 1'b0;
      cnt_r     <= '0;
      acc_r     <= '0;
      mcand_r   <= '0;
      opa_r     <= '0;
      opb_r     <= '0;
      rem_r     <= '0;
      md_hi     <= '0;
      md_lo     <= '0;
    end else if (refresh) begin
      op_mult_r <= 1'b0;
      sa_r      <= 1'b0;
      sb_r      <= 1'b0;
      cnt_r     <= '0;
      acc_r     <= '0;
      mcand_r   <= '0;
      opa_r     <= '0;
      opb_r     <= '0;
      rem_r     <= '0;
      md_hi     <= '0;
      md_lo     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_s) begin
            op_mult_r <= ex_mult;
            sa_r      <= ex_mdsign & ex_A[WIDTH-1];
            sb_r      <= ex_mdsign & ex_B[WIDTH-1];
            cnt_r     <= '0;
            acc_r     <= '0;
            rem_r     <= '0;
            mcand_r   <= {{WIDTH{1'b0}}, abs_w(ex_A, ex_mdsign)};
            opa_r     <= ex_mult ? abs_w(ex_B, ex_mdsign) : abs_w(ex_A, ex_mdsign);
            opb_r     <= abs_w(ex_B, ex_mdsign);
          end
        end
        RUN: begin
          cnt_r <= cnt_r + CW'(1);
          if (op_mult_r) begin
            acc_r   <= acc_next_s;
            mcand_r <= {mcand_r[W2-2:0], 1'b0};
            opa_r   <= {1'b0, opa_r[WIDTH-1:1]};
          end else begin
            rem_r <= rem_next_s;
            opa_r <= {opa_r[WIDTH-2:0], quo_bit_s};
          end
        end
        FIX: begin
          if (op_mult_r) begin
            {md_hi, md_lo} <= (sa_r ^ sb_r) ? neg_2w(acc_r) : acc_r;
          end else begin
            // Quotient takes the sign of A^B, remainder the sign of the dividend.
            md_lo <= (sa_r ^ sb_r) ? neg_w(opa_r) : opa_r;
            md_hi <= sa_r ? neg_w(rem_r) : rem_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random
// operations, with a scoreboard queue filled by the driver and drained by an
// independent monitor on each rising edge of md_valid.
module tb_ex_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, refresh, ex_stall, ex_mult, ex_div, ex_mdsign;
  logic [W-1:0] ex_A, ex_B;
  logic         md_busy, md_valid;
  logic [W-1:0] md_hi, md_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          t;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .refresh(refresh), .ex_stall(ex_stall),
    .ex_mult(ex_mult), .ex_div(ex_div), .ex_mdsign(ex_mdsign),
    .ex_A(ex_A), .ex_B(ex_B), .md_busy(md_busy), .md_valid(md_valid),
    .md_hi(md_hi), .md_lo(md_lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  function automatic logic [63:0] ref_md(input logic m, input logic s,
                                         input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (m) begin
      if (s) return 64'(sa * sb);
      else   return 64'(ua * ub);
    end
    if (b == 32'd0) return {a, ((s && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF)};
    if (s) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  // Monitor: each new result is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (md_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 64'(md_valid), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("md_hi", 64'(md_hi), 64'(mon_e.hi));
        chk("md_lo", 64'(md_lo), 64'(mon_e.lo));
        chk("valid_latency", 64'(cyc - mon_e.t), 64'(W + 2));
      end
    end
    prev_valid <= md_valid;
  end

  // Issue one operation, hold it in EX like the pipeline would, and release it.
  task automatic run_op(input logic m, input logic d, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input int stall_n);
    exp_t e;
    int   busy_n;
    bit   seen;
    logic [63:0] r;
    @(negedge clk);
    ex_mult = m; ex_div = d; ex_mdsign = s; ex_A = a; ex_B = b; ex_stall = 1'b0;
    r = ref_md(m, s, a, b);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.t  = cyc;
    sb_q.push_back(e);
    #1;
    busy_n = 0;
    seen   = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (md_valid) begin
        seen = 1'b1;
      end else begin
        if (md_busy) busy_n++;
        @(negedge clk);
        #1;
      end
    end
    if (!seen) begin
      chk("valid_timeout", 64'd0, 64'd1);
      ex_mult = 1'b0; ex_div = 1'b0;
      return;
    end
    chk("busy_cycles", 64'(busy_n), 64'(W + 2));
    chk("busy_in_done", 64'(md_busy), 64'd0);
    ex_stall = (stall_n > 0);
    for (int j = 1; j <= stall_n; j++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", 64'(md_valid), 64'd1);
      chk("hold_no_busy", 64'(md_busy), 64'd0);
      if (j == stall_n) ex_stall = 1'b0;
    end
    @(negedge clk);
    ex_mult = 1'b0; ex_div = 1'b0;
    #1;
    chk("back_idle_valid", 64'(md_valid), 64'd0);
    chk("back_idle_busy", 64'(md_busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic m, d;
    reset = 1'b1; refresh = 1'b0; ex_stall = 1'b0;
    ex_mult = 1'b0; ex_div = 1'b0; ex_mdsign = 1'b0; ex_A = '0; ex_B = '0;
    @(negedge clk);
    #1;
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_valid", 64'(md_valid), 64'd0);
    chk("rst_hilo", {md_hi, md_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases, including stall-at-DONE with the instruction held.
    run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 1);
    run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 0);
    run_op(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0000, 0);
    run_op(1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 2);
    run_op(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Refresh in RUN at cnt==10: operation discarded, results cleared.
    @(negedge clk);
    ex_mult = 1'b1; ex_mdsign = 1'b0; ex_A = 32'h0000_1234; ex_B = 32'h0000_5678;
    repeat (11) @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    #1;
    chk("rf_busy", 64'(md_busy), 64'd0);
    chk("rf_valid", 64'(md_valid), 64'd0);
    chk("rf_hilo", {md_hi, md_lo}, 64'd0);
    refresh = 1'b0; ex_mult = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("rf_stays_idle", 64'(md_valid), 64'd0);

    // Asynchronous reset mid-RUN after a nonzero result.
    run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    ex_mult = 1'b1; ex_A = 32'h0000_00FF; ex_B = 32'h0000_0101;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1; ex_mult = 1'b0;
    #1;
    chk("ar_busy", 64'(md_busy), 64'd0);
    chk("ar_valid", 64'(md_valid), 64'd0);
    chk("ar_hilo", {md_hi, md_lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("ar_stays_idle", 64'(md_valid), 64'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom % 2);
      d = m ? 1'($urandom % 4 == 0) : 1'b1;
      run_op(m, d, 1'($urandom % 2), pick(), pick(), int'($urandom % 4));
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
